alu_in_capture_monitor: RTL and testbench
=========================================

// Module: alu_in_capture_monitor
// PURPOSE
// Synthesizable multi-channel capture monitor for ALU_in buses; runs in the emulated HDL domain.
// Samples NUM_CH ALU_in channels and records each accepted operand transfer and each ALU-reset entry.
// Records are merged round-robin into one FIFO and streamed out over a valid/ready port to the HVL proxy.
// PARAMETERS
// NUM_CH           4     number of monitored ALU_in channels (1..16)
// ALU_IN_OP_WIDTH  8     operand width of a/b
// DEPTH            16    record FIFO depth, power of two >= 2
// RST_OP           3'd5  op code written into reset records
// TS_WIDTH         32    timestamp width (only with ALU_IN_CAPTURE_TIMESTAMP_EN)
// PORTS
// clk          in   1                      clock, all logic on posedge
// rst          in   1                      synchronous, active-high reset
// enable       in   1                      1 = capture new events; 0 = no capture, drain continues
// ch_alu_rst   in   NUM_CH                 per-channel ALU reset, active-low
// ch_valid     in   NUM_CH                 per-channel valid
// ch_ready     in   NUM_CH                 per-channel ready
// ch_op        in   3*NUM_CH               op codes, channel c at [3c+:3]
// ch_a, ch_b   in   ALU_IN_OP_WIDTH*NUM_CH operands, channel c at [W*c+:W]
// rec_valid    out  1                      FIFO head record available
// rec_ready    in   1                      consumer accepts head when rec_valid & rec_ready
// rec_chan     out  $clog2(NUM_CH) (min 1) source channel
// rec_op       out  3                      captured op or RST_OP
// rec_a, rec_b out  ALU_IN_OP_WIDTH        captured operands; 0 for reset records
// rec_ts       out  TS_WIDTH               capture timestamp (port exists only with macro)
// fifo_count   out  $clog2(DEPTH)+1        records currently held
// drop_count   out  16                     saturating count of lost events
// BEHAVIOUR
// Reset: rec_valid=0, fifo_count=0, drop_count=0, pending regs empty.
//   rec_chan/op/a/b=0, rr pointer=0, prev_alu_rst=1 for all channels.
// Events on channel c are sampled at posedge clk while enable=1:
//   XFER: ch_alu_rst[c]=1 & ch_valid[c]=1 & ch_ready[c]=1 -> {c, op, a, b}.
//   RSTE: ch_alu_rst[c]=0 & prev_alu_rst[c]=1 -> {c, RST_OP, 0, 0}.
//   RSTE fires once per low period; no records while alu_rst stays low.
//   A channel held low out of reset yields exactly one RSTE.
// prev_alu_rst[c] updates every cycle regardless of enable.
// Pending stage: one record register per channel.
//   An event loads it if the register is empty or is granted in the same cycle.
//   Otherwise the event is dropped and drop_count increments (saturates at 16'hFFFF).
// Arbiter: round-robin over pending channels, starting at rr pointer.
//   Grants one per cycle when fifo_count<DEPTH, or when ==DEPTH with a pop in the same cycle.
//   rr pointer <= granted index+1 mod NUM_CH; unchanged when no grant.
// FIFO: granted record is written at the same edge. Head is first-word fall-through.
//   rec_valid = (fifo_count!=0). Push and pop in one cycle leave fifo_count unchanged.
//   Pointers wrap mod DEPTH.
// Latency: event at edge k -> pending after k -> in FIFO, rec_valid=1 after edge k+1 (uncontended).
// Ordering: per-channel order preserved; cross-channel order follows grant order.
// enable=0: new events ignored (not counted as drops); pending and FIFO still drain.
// rst asserted mid-operation: all pending/FIFO contents discarded, state returns to reset values next edge.
// Outputs rec_* hold stable while rec_valid=1 and rec_ready=0.
// CONFIGURATION
// ALU_IN_CAPTURE_TIMESTAMP_EN defined:
//   free-running TS_WIDTH counter, 0 after rst, +1 per cycle, wraps to 0.
//   Each record stores the counter value at its sampling edge; the value is presented on rec_ts.
// Undefined: no counter, no rec_ts port, record storage excludes timestamp.
//   All other behaviour identical.
// TESTING
// Single XFER ch0 op=1 a=8'h12 b=8'h34 -> rec after 2 edges {0,1,12,34}; fifo_count=1; pop -> rec_valid=0.
// ch1 alu_rst low for 5 cycles -> exactly one record {1,RST_OP,0,0}; release+re-assert -> one more.
// XFER on all 4 channels same cycle, rec_ready=1 -> records ch0,ch1,ch2,ch3 on 4 consecutive cycles.
//   Next simultaneous burst starts at rr pointer.
// rec_ready=0, ch2 XFER every cycle -> FIFO fills to 16, pending fills, further XFERs drop.
//   drop_count increments per cycle; pop once -> one grant, count stays 16.
// enable=0 with XFERs on all channels -> no records, drop_count unchanged; rst mid-burst -> fifo_count=0 next edge.
// With ALU_IN_CAPTURE_TIMESTAMP_EN, TS_WIDTH=4: XFER at cycle 3 and cycle 19 -> rec_ts=3 then 3 (wrap).

Source files
------------

// File: rtl/alu_in_capture_monitor.sv
`default_nettype none
// ============================================================================
// Module      : alu_in_capture_monitor
// Description : Multi-channel ALU_in capture monitor. Per-channel transfer and
//               ALU-reset-entry events are held in a one-deep pending stage,
//               merged round-robin into a first-word fall-through record FIFO
//               and streamed out over a valid/ready port.
//               Optional macro ALU_IN_CAPTURE_TIMESTAMP_EN adds a free-running
//               timestamp stored with every record and presented on rec_ts.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_in_capture_monitor #(
    parameter int         NUM_CH          = 4,
    parameter int         ALU_IN_OP_WIDTH = 8,
    parameter int         DEPTH           = 16,
    parameter logic [2:0] RST_OP          = 3'd5
`ifdef ALU_IN_CAPTURE_TIMESTAMP_EN
    ,
    parameter int         TS_WIDTH        = 32
`endif
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              enable,
    input  logic [NUM_CH-1:0]                 ch_alu_rst,
    input  logic [NUM_CH-1:0]                 ch_valid,
    input  logic [NUM_CH-1:0]                 ch_ready,
    input  logic [3*NUM_CH-1:0]               ch_op,
    input  logic [ALU_IN_OP_WIDTH*NUM_CH-1:0] ch_a,
    input  logic [ALU_IN_OP_WIDTH*NUM_CH-1:0] ch_b,
    output logic                              rec_valid,
    input  logic                              rec_ready,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] rec_chan,
    output logic [2:0]                        rec_op,
    output logic [ALU_IN_OP_WIDTH-1:0]        rec_a,
    output logic [ALU_IN_OP_WIDTH-1:0]        rec_b,
`ifdef ALU_IN_CAPTURE_TIMESTAMP_EN
    output logic [TS_WIDTH-1:0]               rec_ts,
`endif
    output logic [$clog2(DEPTH):0]            fifo_count,
    output logic [15:0]                       drop_count
);

    localparam int c_chan_w = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int c_ptr_w  = $clog2(DEPTH);
    localparam int c_op_w   = ALU_IN_OP_WIDTH;
    localparam logic [c_chan_w-1:0] c_last_ch = c_chan_w'(NUM_CH - 1);
    localparam logic [c_ptr_w:0]    c_depth   = (c_ptr_w + 1)'(DEPTH);

    // Per-channel event decode
    logic [NUM_CH-1:0] w_evt;
    logic [NUM_CH-1:0] w_drop;
    logic [NUM_CH-1:0] w_gnt;
    logic [2:0]        w_evt_op [NUM_CH];
    logic [c_op_w-1:0] w_evt_a  [NUM_CH];
    logic [c_op_w-1:0] w_evt_b  [NUM_CH];

    logic [NUM_CH-1:0] r_prev_alu_rst;
    logic [NUM_CH-1:0] r_pend_vld;
    logic [2:0]        r_pend_op [NUM_CH];
    logic [c_op_w-1:0] r_pend_a  [NUM_CH];
    logic [c_op_w-1:0] r_pend_b  [NUM_CH];
`ifdef ALU_IN_CAPTURE_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] r_ts;
    logic [TS_WIDTH-1:0] r_pend_ts [NUM_CH];
    logic [TS_WIDTH-1:0] r_mem_ts  [DEPTH];
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign w_evt[gi] = enable &
                ((ch_alu_rst[gi] & ch_valid[gi] & ch_ready[gi]) |
                 (~ch_alu_rst[gi] & r_prev_alu_rst[gi]));
            assign w_evt_op[gi] = ch_alu_rst[gi] ? ch_op[3*gi +: 3] : RST_OP;
            assign w_evt_a[gi]  = ch_alu_rst[gi] ? ch_a[c_op_w*gi +: c_op_w] : '0;
            assign w_evt_b[gi]  = ch_alu_rst[gi] ? ch_b[c_op_w*gi +: c_op_w] : '0;
            assign w_drop[gi]   = w_evt[gi] & r_pend_vld[gi] & ~w_gnt[gi];
        end
    endgenerate

    // FIFO state
    logic [c_chan_w-1:0] r_mem_chan [DEPTH];
    logic [2:0]          r_mem_op   [DEPTH];
    logic [c_op_w-1:0]   r_mem_a    [DEPTH];
    logic [c_op_w-1:0]   r_mem_b    [DEPTH];
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_ptr_w:0]    r_count;
    logic [15:0]         r_drop;
    logic [c_chan_w-1:0] r_rr;

    logic                w_pop;
    logic                w_can_grant;
    logic                w_gnt_any;
    logic [c_chan_w-1:0] w_gnt_idx;
    logic [c_chan_w-1:0] w_scan_idx;
    logic [4:0]          w_ndrop;
    logic [16:0]         w_drop_sum;

    assign rec_valid   = (r_count != '0);
    assign w_pop       = rec_valid & rec_ready;
    // A full FIFO can still take a record when the head leaves this cycle
    assign w_can_grant = (r_count != c_depth) | w_pop;

    always_comb begin
        w_gnt      = '0;
        w_gnt_any  = 1'b0;
        w_gnt_idx  = '0;
        w_scan_idx = r_rr;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!w_gnt_any && w_can_grant && r_pend_vld[w_scan_idx]) begin
                w_gnt_any            = 1'b1;
                w_gnt_idx            = w_scan_idx;
                w_gnt[w_scan_idx]    = 1'b1;
            end
            w_scan_idx = (w_scan_idx == c_last_ch) ? '0 : w_scan_idx + c_chan_w'(1);
        end
    end

    always_comb begin
        w_ndrop = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_ndrop = w_ndrop + {4'b0000, w_drop[c]};
        end
        w_drop_sum = {1'b0, r_drop} + {12'b0, w_ndrop};
    end

    // Pending stage: a granted slot may be reloaded on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_alu_rst <= '1;
            r_pend_vld     <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_pend_op[c] <= '0;
                r_pend_a[c]  <= '0;
                r_pend_b[c]  <= '0;
`ifdef ALU_IN_CAPTURE_TIMESTAMP_EN
                r_pend_ts[c] <= '0;
`endif
            end
        end else begin
            r_prev_alu_rst <= ch_alu_rst;
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_evt[c] && (!r_pend_vld[c] || w_gnt[c])) begin
                    r_pend_vld[c] <= 1'b1;
                    r_pend_op[c]  <= w_evt_op[c];
                    r_pend_a[c]   <= w_evt_a[c];
                    r_pend_b[c]   <= w_evt_b[c];
`ifdef ALU_IN_CAPTURE_TIMESTAMP_EN
                    r_pend_ts[c]  <= r_ts;
`endif
                end else if (w_gnt[c]) begin
                    r_pend_vld[c] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_gnt_any) begin
            r_mem_chan[r_wr_ptr] <= w_gnt_idx;
            r_mem_op[r_wr_ptr]   <= r_pend_op[w_gnt_idx];
            r_mem_a[r_wr_ptr]    <= r_pend_a[w_gnt_idx];
            r_mem_b[r_wr_ptr]    <= r_pend_b[w_gnt_idx];
`ifdef ALU_IN_CAPTURE_TIMESTAMP_EN
            r_mem_ts[r_wr_ptr]   <= r_pend_ts[w_gnt_idx];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_drop   <= '0;
            r_rr     <= '0;
        end else begin
            if (w_gnt_any) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
                r_rr     <= (w_gnt_idx == c_last_ch) ? '0 : w_gnt_idx + c_chan_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_gnt_any, w_pop})
                2'b10:   r_count <= r_count + (c_ptr_w + 1)'(1);
                2'b01:   r_count <= r_count - (c_ptr_w + 1)'(1);
                default: r_count <= r_count;
            endcase
            r_drop <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end
    end

`ifdef ALU_IN_CAPTURE_TIMESTAMP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + TS_WIDTH'(1);
        end
    end

    assign rec_ts = rec_valid ? r_mem_ts[r_rd_ptr] : '0;
`endif

    // Head fields read as zero whenever the FIFO is empty
    assign rec_chan   = rec_valid ? r_mem_chan[r_rd_ptr] : '0;
    assign rec_op     = rec_valid ? r_mem_op[r_rd_ptr]   : '0;
    assign rec_a      = rec_valid ? r_mem_a[r_rd_ptr]    : '0;
    assign rec_b      = rec_valid ? r_mem_b[r_rd_ptr]    : '0;
    assign fifo_count = r_count;
    assign drop_count = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_alu_in_capture_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_in_capture_monitor
// Description : Self-checking bench for alu_in_capture_monitor with directed
//               scenarios and a randomized run against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_in_capture_monitor;

    localparam int         N     = 4;
    localparam int         W     = 8;
    localparam int         D     = 16;
    localparam logic [2:0] RSTOP = 3'd5;
    localparam int         TSW   = 32;

    logic           clk;
    logic           rst;
    logic           enable;
    logic [N-1:0]   ch_alu_rst;
    logic [N-1:0]   ch_valid;
    logic [N-1:0]   ch_ready;
    logic [3*N-1:0] ch_op;
    logic [W*N-1:0] ch_a;
    logic [W*N-1:0] ch_b;
    logic           rec_valid;
    logic           rec_ready;
    logic [1:0]     rec_chan;
    logic [2:0]     rec_op;
    logic [W-1:0]   rec_a;
    logic [W-1:0]   rec_b;
    logic [4:0]     fifo_count;
    logic [15:0]    drop_count;
`ifdef ALU_IN_CAPTURE_TIMESTAMP_EN
    logic [TSW-1:0] rec_ts;
`endif

    int n_cmp;
    int n_fail;

    alu_in_capture_monitor #(
        .NUM_CH          (N),
        .ALU_IN_OP_WIDTH (W),
        .DEPTH           (D),
        .RST_OP          (RSTOP)
`ifdef ALU_IN_CAPTURE_TIMESTAMP_EN
        ,
        .TS_WIDTH        (TSW)
`endif
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .ch_alu_rst (ch_alu_rst),
        .ch_valid   (ch_valid),
        .ch_ready   (ch_ready),
        .ch_op      (ch_op),
        .ch_a       (ch_a),
        .ch_b       (ch_b),
        .rec_valid  (rec_valid),
        .rec_ready  (rec_ready),
        .rec_chan   (rec_chan),
        .rec_op     (rec_op),
        .rec_a      (rec_a),
        .rec_b      (rec_b),
`ifdef ALU_IN_CAPTURE_TIMESTAMP_EN
        .rec_ts     (rec_ts),
`endif
        .fifo_count (fifo_count),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pending slots and a record queue
    typedef struct {
        int     chan;
        int     op;
        int     a;
        int     b;
        longint ts;
    } rec_t;

    rec_t   m_q[$];
    rec_t   m_pend[N];
    bit     m_pv[N];
    bit     m_prev[N];
    int     m_rr;
    int     m_drop;
    longint m_ts;

    function automatic void model_step();
        bit pop;
        int g;
        bit xfer;
        bit rste;
        if (rst) begin
            m_q.delete();
            for (int c = 0; c < N; c++) begin
                m_pv[c]   = 1'b0;
                m_prev[c] = 1'b1;
            end
            m_rr   = 0;
            m_drop = 0;
            m_ts   = 0;
            return;
        end
        pop = (m_q.size() != 0) && rec_ready;
        g   = -1;
        if (m_q.size() < D || pop) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && m_pv[(m_rr + k) % N]) g = (m_rr + k) % N;
            end
        end
        if (pop) void'(m_q.pop_front());
        if (g >= 0) begin
            m_q.push_back(m_pend[g]);
            m_pv[g] = 1'b0;
            m_rr    = (g + 1) % N;
        end
        for (int c = 0; c < N; c++) begin
            xfer = ch_alu_rst[c] && ch_valid[c] && ch_ready[c];
            rste = !ch_alu_rst[c] && m_prev[c];
            if (enable && (xfer || rste)) begin
                if (!m_pv[c]) begin
                    m_pend[c].chan = c;
                    m_pend[c].op   = xfer ? int'(ch_op[3*c +: 3]) : int'(RSTOP);
                    m_pend[c].a    = xfer ? int'(ch_a[W*c +: W]) : 0;
                    m_pend[c].b    = xfer ? int'(ch_b[W*c +: W]) : 0;
                    m_pend[c].ts   = m_ts;
                    m_pv[c]        = 1'b1;
                end else if (m_drop < 65535) begin
                    m_drop++;
                end
            end
            m_prev[c] = ch_alu_rst[c];
        end
        m_ts = (m_ts + 1) & ((64'd1 << TSW) - 1);
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        enable     = 1'b1;
        ch_alu_rst = '1;
        ch_valid   = '0;
        ch_ready   = '0;
        ch_op      = '0;
        ch_a       = '0;
        ch_b       = '0;
        rec_ready  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (rec_valid !== 1'b0 || fifo_count !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_flags: got valid=%b count=%0d, want valid=0 count=0", rec_valid, fifo_count);
        end
        n_cmp++;
        if (drop_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_drop: got %0d, want 0", drop_count);
        end
        n_cmp++;
        if (rec_chan !== 2'd0 || rec_op !== 3'd0 || rec_a !== 8'd0 || rec_b !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_fields: got chan=%0d op=%0d a=%h b=%h, want all 0", rec_chan, rec_op, rec_a, rec_b);
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (rec_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got valid=%b, want 0", rec_valid);
        end
    endtask

    task automatic test_single_xfer();
        set_idle();
        ch_valid[0]  = 1'b1;
        ch_ready[0]  = 1'b1;
        ch_op[2:0]   = 3'd1;
        ch_a[7:0]    = 8'h12;
        ch_b[7:0]    = 8'h34;
        tick();
        set_idle();
        n_cmp++;
        if (rec_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_latency: got valid=%b after 1 edge, want 0", rec_valid);
        end
        tick();
        n_cmp++;
        if (rec_valid !== 1'b1 || rec_chan !== 2'd0 || rec_op !== 3'd1 ||
            rec_a !== 8'h12 || rec_b !== 8'h34 || fifo_count !== 5'd1) begin
            n_fail++;
            $display("FAIL single_record: got v=%b ch=%0d op=%0d a=%h b=%h cnt=%0d, want 1 0 1 12 34 1",
                     rec_valid, rec_chan, rec_op, rec_a, rec_b, fifo_count);
        end
        rec_ready = 1'b1;
        tick();
        rec_ready = 1'b0;
        n_cmp++;
        if (rec_valid !== 1'b0 || fifo_count !== 5'd0) begin
            n_fail++;
            $display("FAIL single_pop: got valid=%b count=%0d, want 0 0", rec_valid, fifo_count);
        end
    endtask

    task automatic test_reset_entry();
        set_idle();
        ch_alu_rst[1] = 1'b0;
        repeat (5) tick();
        ch_alu_rst[1] = 1'b1;
        tick();
        n_cmp++;
        if (fifo_count !== 5'd1 || rec_chan !== 2'd1 || rec_op !== RSTOP || rec_a !== 8'd0 || rec_b !== 8'd0) begin
            n_fail++;
            $display("FAIL rste_first: got cnt=%0d ch=%0d op=%0d a=%h b=%h, want 1 1 5 0 0",
                     fifo_count, rec_chan, rec_op, rec_a, rec_b);
        end
        ch_alu_rst[1] = 1'b0;
        repeat (3) tick();
        ch_alu_rst[1] = 1'b1;
        tick();
        n_cmp++;
        if (fifo_count !== 5'd2) begin
            n_fail++;
            $display("FAIL rste_second: got count=%0d, want 2", fifo_count);
        end
        rec_ready = 1'b1;
        tick();
        tick();
        rec_ready = 1'b0;
        n_cmp++;
        if (fifo_count !== 5'd0) begin
            n_fail++;
            $display("FAIL rste_drain: got count=%0d, want 0", fifo_count);
        end
    endtask

    task automatic test_back_to_back();
        int exp1[4];
        int exp2[4];
        exp1 = '{0, 1, 2, 3};
        exp2 = '{2, 3, 0, 1};
        set_idle();
        do_reset();
        rec_ready = 1'b1;
        ch_valid  = '1;
        ch_ready  = '1;
        ch_op     = {3'd4, 3'd3, 3'd2, 3'd1};
        tick();
        ch_valid = '0;
        for (int j = 0; j < 4; j++) begin
            tick();
            n_cmp++;
            if (rec_valid !== 1'b1 || rec_chan !== 2'(exp1[j]) || rec_op !== 3'(exp1[j] + 1)) begin
                n_fail++;
                $display("FAIL burst1_order[%0d]: got v=%b ch=%0d op=%0d, want v=1 ch=%0d op=%0d",
                         j, rec_valid, rec_chan, rec_op, exp1[j], exp1[j] + 1);
            end
        end
        tick();
        ch_valid = 4'b0011;
        tick();
        ch_valid = '0;
        tick();
        tick();
        tick();
        ch_valid = '1;
        tick();
        ch_valid = '0;
        for (int j = 0; j < 4; j++) begin
            tick();
            n_cmp++;
            if (rec_valid !== 1'b1 || rec_chan !== 2'(exp2[j])) begin
                n_fail++;
                $display("FAIL burst_rr_order[%0d]: got v=%b ch=%0d, want v=1 ch=%0d", j, rec_valid, rec_chan, exp2[j]);
            end
        end
        tick();
        rec_ready = 1'b0;
        n_cmp++;
        if (rec_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL burst_drain: got valid=%b, want 0", rec_valid);
        end
    endtask

    task automatic test_fill();
        set_idle();
        do_reset();
        ch_valid[2] = 1'b1;
        ch_ready[2] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            ch_a[23:16] = i[7:0];
            tick();
        end
        n_cmp++;
        if (fifo_count !== 5'd16 || drop_count !== 16'd3 || rec_a !== 8'd0) begin
            n_fail++;
            $display("FAIL fill_full: got cnt=%0d drop=%0d a=%0d, want 16 3 0", fifo_count, drop_count, rec_a);
        end
        ch_a[23:16] = 8'd20;
        tick();
        n_cmp++;
        if (drop_count !== 16'd4) begin
            n_fail++;
            $display("FAIL fill_drop_step: got %0d, want 4", drop_count);
        end
        ch_valid  = '0;
        rec_ready = 1'b1;
        tick();
        rec_ready = 1'b0;
        n_cmp++;
        if (fifo_count !== 5'd16 || drop_count !== 16'd4 || rec_a !== 8'd1) begin
            n_fail++;
            $display("FAIL fill_pop_regrant: got cnt=%0d drop=%0d a=%0d, want 16 4 1", fifo_count, drop_count, rec_a);
        end
    endtask

    task automatic test_enable_off();
        enable    = 1'b0;
        ch_valid  = '1;
        ch_ready  = '1;
        rec_ready = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (fifo_count !== 5'd13 || drop_count !== 16'd4) begin
            n_fail++;
            $display("FAIL enable_off: got cnt=%0d drop=%0d, want 13 4", fifo_count, drop_count);
        end
        enable = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (fifo_count !== 5'd0 || rec_valid !== 1'b0 || drop_count !== 16'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got cnt=%0d v=%b drop=%0d, want 0 0 0", fifo_count, rec_valid, drop_count);
        end
        set_idle();
        tick();
        n_cmp++;
        if (rec_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_flush: got valid=%b, want 0", rec_valid);
        end
    endtask

    task automatic test_random();
        logic        e_valid;
        logic [1:0]  e_chan;
        logic [2:0]  e_op;
        logic [7:0]  e_a;
        logic [7:0]  e_b;
        logic [4:0]  e_cnt;
        logic [15:0] e_drop;
        set_idle();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 149) == 0);
            enable    = ($urandom_range(0, 9) != 0);
            rec_ready = ($urandom_range(0, 9) < 5);
            for (int c = 0; c < N; c++) begin
                ch_alu_rst[c] = ($urandom_range(0, 7) != 0);
                ch_valid[c]   = ($urandom_range(0, 1) == 1);
                ch_ready[c]   = ($urandom_range(0, 3) != 0);
            end
            ch_op = 12'($urandom);
            ch_a  = $urandom;
            ch_b  = $urandom;
            tick();
            e_valid = (m_q.size() != 0);
            e_chan  = e_valid ? 2'(m_q[0].chan) : 2'd0;
            e_op    = e_valid ? 3'(m_q[0].op)   : 3'd0;
            e_a     = e_valid ? 8'(m_q[0].a)    : 8'd0;
            e_b     = e_valid ? 8'(m_q[0].b)    : 8'd0;
            e_cnt   = 5'(m_q.size());
            e_drop  = 16'(m_drop);
            n_cmp++;
            if (rec_valid !== e_valid || rec_chan !== e_chan || rec_op !== e_op || rec_a !== e_a ||
                rec_b !== e_b || fifo_count !== e_cnt || drop_count !== e_drop) begin
                n_fail++;
                $display("FAIL random[%0d]: got v=%b ch=%0d op=%0d a=%h b=%h cnt=%0d drop=%0d, want v=%b ch=%0d op=%0d a=%h b=%h cnt=%0d drop=%0d",
                         i, rec_valid, rec_chan, rec_op, rec_a, rec_b, fifo_count, drop_count,
                         e_valid, e_chan, e_op, e_a, e_b, e_cnt, e_drop);
            end
`ifdef ALU_IN_CAPTURE_TIMESTAMP_EN
            n_cmp++;
            if (rec_ts !== (e_valid ? TSW'(m_q[0].ts) : TSW'(0))) begin
                n_fail++;
                $display("FAIL random_ts[%0d]: got %0d, want %0d", i, rec_ts, e_valid ? m_q[0].ts : 0);
            end
`endif
        end
        rst = 1'b0;
        set_idle();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        set_idle();
        test_reset();
        test_single_xfer();
        test_reset_entry();
        test_back_to_back();
        test_fill();
        test_enable_off();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
